// File: rtl/program_counter_pkg.sv
// Shared instruction definitions for the sequencing stage: field positions, PC width and opcodes.
package program_counter_pkg;

    localparam int unsigned PC_WIDTH    = 16;
    localparam int unsigned INSTR_WIDTH = 24;
    localparam int unsigned OP_MSB      = 23;
    localparam int unsigned OP_LSB      = 16;
    localparam int unsigned OPR_MSB     = 15;
    localparam int unsigned OPR_LSB     = 0;

    typedef enum logic [7:0] {
        OpNop = 8'h00,
        OpLd  = 8'h01,
        OpLdi = 8'h02,
        OpSt  = 8'h03,
        OpAdd = 8'h04,
        OpInc = 8'h05,
        OpDec = 8'h06,
        OpJmp = 8'h07,
        OpJma = 8'h08,
        OpCll = 8'h09,
        OpRet = 8'h0A,
        OpRst = 8'h0B
    } opcode_e;

endpackage

// File: rtl/program_counter_ret_stack.sv
// Return-address stack for CLL/RET: storage, depth counter and the optional overflow/underflow
// guard (enabled by defining PC_STACK_GUARD_EN).
module ret_stack
    import program_counter_pkg::*;
#(
    parameter int unsigned STACK_DEPTH = 8,
    parameter int unsigned SP_WIDTH    = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                push_i,
    input  logic                pop_i,
    input  logic                clear_i,
    input  logic [PC_WIDTH-1:0] push_data_i,
    output logic [PC_WIDTH-1:0] top_o,
    output logic [SP_WIDTH:0]   depth_o,
    output logic                trip_o,
    output logic                fault_o
);

    logic [PC_WIDTH-1:0] mem_q [STACK_DEPTH];
    logic [SP_WIDTH:0]   depth_q, depth_d;
    logic [SP_WIDTH-1:0] sp_lo, rd_idx;
    logic                do_push, do_pop;

    // Pointer arithmetic is modulo STACK_DEPTH on the low bits, so a full stack writes entry 0
    // and an empty one reads entry STACK_DEPTH-1 when the guard is absent.
    assign sp_lo   = depth_q[SP_WIDTH-1:0];
    assign rd_idx  = sp_lo - SP_WIDTH'(1);
    assign top_o   = mem_q[rd_idx];
    assign depth_o = depth_q;
    assign do_push = en_i & push_i & ~trip_o;
    assign do_pop  = en_i & pop_i & ~trip_o;

`ifdef PC_STACK_GUARD_EN
    logic fault_q;
    logic full, empty;

    assign full    = (depth_q == (SP_WIDTH+1)'(STACK_DEPTH));
    assign empty   = (depth_q == '0);
    assign trip_o  = (push_i & full) | (pop_i & empty);
    assign fault_o = fault_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fault_q <= 1'b0;
        end else if (en_i && trip_o) begin
            fault_q <= 1'b1;
        end
    end
`else
    assign trip_o  = 1'b0;
    assign fault_o = 1'b0;
`endif

    always_comb begin
        depth_d = depth_q;
        if (en_i && clear_i) begin
            depth_d = '0;
        end else if (do_push) begin
            depth_d = {1'b0, sp_lo} + (SP_WIDTH+1)'(1);
        end else if (do_pop) begin
            depth_d = {1'b0, rd_idx};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            depth_q <= '0;
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            depth_q <= depth_d;
            if (do_push) begin
                mem_q[sp_lo] <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/program_counter.sv
// Program counter with control-flow decode (JMP/JMA/CLL/RET/RST) and a return-address stack.
// Optional stack guard: define PC_STACK_GUARD_EN.
module program_counter
    import program_counter_pkg::*;
#(
    parameter int unsigned STACK_DEPTH = 8,
    parameter int unsigned SP_WIDTH    = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic [INSTR_WIDTH-1:0] instr_i,
    input  logic                   acc_nz_i,
    output logic [PC_WIDTH-1:0]    pc_o,
    output logic [SP_WIDTH:0]      depth_o,
    output logic                   fault_o
);

    opcode_e             op;
    logic [PC_WIDTH-1:0] opr;
    logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc, stack_top;
    logic                active, trip;

    assign op     = opcode_e'(instr_i[OP_MSB:OP_LSB]);
    assign opr    = instr_i[OPR_MSB:OPR_LSB];
    assign pc_inc = pc_q + PC_WIDTH'(1);
    // A latched fault halts the unit exactly like a stall.
    assign active = en_i & ~fault_o;
    assign pc_o   = pc_q;

    ret_stack #(
        .STACK_DEPTH(STACK_DEPTH),
        .SP_WIDTH   (SP_WIDTH)
    ) u_ret_stack (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (active),
        .push_i     (op == OpCll),
        .pop_i      (op == OpRet),
        .clear_i    (op == OpRst),
        .push_data_i(pc_inc),
        .top_o      (stack_top),
        .depth_o    (depth_o),
        .trip_o     (trip),
        .fault_o    (fault_o)
    );

    always_comb begin
        pc_d = pc_q;
        if (active && !trip) begin
            case (op)
                OpJmp:   pc_d = opr;
                OpJma:   pc_d = acc_nz_i ? opr : pc_inc;
                OpCll:   pc_d = opr;
                OpRet:   pc_d = stack_top;
                OpRst:   pc_d = '0;
                default: pc_d = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule
